// File: rtl/exibe_sequencia_if.sv
`default_nettype none
// ============================================================================
//  Module   : exibe_sequencia_if
//  Purpose  : Bundles the signals exibe_sequencia shares with the game
//             control unit, the sequence memory and the LED drivers.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    iniciar      control -> presenter  start request
//    limite       control -> presenter  index of the last entry to show
//    mem_dado     memory  -> presenter  word at mem_endereco (async read)
//    mem_endereco presenter -> memory   current read address
//    leds         presenter -> LEDs     LED drive, zero when dark
//    ocupado      presenter -> control  high while presenting
//    pronto       presenter -> control  one-cycle end-of-presentation pulse
//    db_estado    presenter -> debug    current state code
//  Modports
//    slave  : the presenter (exibe_sequencia)
//    master : its environment (control unit, memory, LED sink)
// ============================================================================
interface exibe_sequencia_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              iniciar;
    logic [ADDR_W-1:0] limite;
    logic [DATA_W-1:0] mem_dado;
    logic [ADDR_W-1:0] mem_endereco;
    logic [DATA_W-1:0] leds;
    logic              ocupado;
    logic              pronto;
    logic [2:0]        db_estado;

    modport slave (
        input  iniciar,
        input  limite,
        input  mem_dado,
        output mem_endereco,
        output leds,
        output ocupado,
        output pronto,
        output db_estado
    );

    modport master (
        output iniciar,
        output limite,
        output mem_dado,
        input  mem_endereco,
        input  leds,
        input  ocupado,
        input  pronto,
        input  db_estado
    );
endinterface
`default_nettype wire

// File: rtl/exibe_sequencia.sv
`default_nettype none
// ============================================================================
//  Module   : exibe_sequencia
//  Purpose  : Sequence presenter for the memory game. On iniciar it reads
//             memory positions 0..limite and lights each word on the LEDs
//             for T_ON cycles followed by a T_OFF dark gap, then pulses
//             pronto for one cycle.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W  width of memory address and limite
//    DATA_W  width of a memory word and of leds
//    T_ON    cycles each entry is lit (>= 1)
//    T_OFF   cycles of dark gap after each entry (>= 1)
//  Ports
//    clock   system clock, rising edge
//    reset   asynchronous, active-high; returns to ocioso
//    parar   abort request (only with EXIBE_SEQUENCIA_ABORTA_EN)
//    bus     exibe_sequencia_if.slave: iniciar, limite, mem_dado in;
//            mem_endereco, leds, ocupado, pronto, db_estado out
//  Build option
//    EXIBE_SEQUENCIA_ABORTA_EN  adds the parar input; parar in carrega,
//                               aceso or apagado returns to ocioso with no
//                               pronto pulse.
//  State codes (db_estado): ocioso 0, carrega 1, aceso 2, apagado 3, fim 4,
//                           any illegal code reads as 7.
// ============================================================================
module exibe_sequencia #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int T_ON   = 1000,
    parameter int T_OFF  = 500
) (
    input  wire              clock,
    input  wire              reset,
`ifdef EXIBE_SEQUENCIA_ABORTA_EN
    input  wire              parar,
`endif
    exibe_sequencia_if.slave bus
);

    // Timer only has to reach max(T_ON, T_OFF) - 1.
    localparam int T_MAX   = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TIMER_W-1:0] C_TON_LAST  = TIMER_W'(T_ON - 1);
    localparam logic [TIMER_W-1:0] C_TOFF_LAST = TIMER_W'(T_OFF - 1);

    typedef enum logic [2:0] {
        S_OCIOSO  = 3'd0,
        S_CARREGA = 3'd1,
        S_ACESO   = 3'd2,
        S_APAGADO = 3'd3,
        S_FIM     = 3'd4
    } estado_t;

    estado_t             state_q,  state_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [ADDR_W-1:0]   limite_q, limite_d;
    logic [DATA_W-1:0]   leds_q,   leds_d;
    logic [TIMER_W-1:0]  timer_q,  timer_d;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_OCIOSO;
            addr_q   <= '0;
            limite_q <= '0;
            leds_q   <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            limite_q <= limite_d;
            leds_q   <= leds_d;
            timer_q  <= timer_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        limite_d = limite_q;
        leds_d   = leds_q;
        timer_d  = timer_q;

        case (state_q)
            S_OCIOSO: begin
                if (bus.iniciar) begin
                    state_d  = S_CARREGA;
                    addr_d   = '0;
                    limite_d = bus.limite;
                end
            end

            S_CARREGA: begin
                // The only cycle mem_dado is sampled: later memory changes
                // cannot disturb the entry being shown.
                leds_d  = bus.mem_dado;
                timer_d = '0;
                state_d = S_ACESO;
            end

            S_ACESO: begin
                if (timer_q == C_TON_LAST) begin
                    timer_d = '0;
                    state_d = S_APAGADO;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            S_APAGADO: begin
                if (timer_q == C_TOFF_LAST) begin
                    timer_d = '0;
                    // End test comes before the increment, so a limite at
                    // the top of the address range never wraps to 0.
                    if (addr_q == limite_q) begin
                        state_d = S_FIM;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_CARREGA;
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            S_FIM: begin
                addr_d  = '0;
                state_d = S_OCIOSO;
            end

            default: begin
                // Illegal encodings recover to idle on the next edge.
                addr_d  = '0;
                timer_d = '0;
                state_d = S_OCIOSO;
            end
        endcase

`ifdef EXIBE_SEQUENCIA_ABORTA_EN
        // Applied after the case so it wins over every timer-end transition.
        if (parar && ((state_q == S_CARREGA) ||
                      (state_q == S_ACESO)   ||
                      (state_q == S_APAGADO))) begin
            state_d = S_OCIOSO;
            addr_d  = '0;
            timer_d = '0;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    logic [2:0] w_db_estado;

    always_comb begin
        w_db_estado = 3'd7;
        case (state_q)
            S_OCIOSO:  w_db_estado = 3'd0;
            S_CARREGA: w_db_estado = 3'd1;
            S_ACESO:   w_db_estado = 3'd2;
            S_APAGADO: w_db_estado = 3'd3;
            S_FIM:     w_db_estado = 3'd4;
            default:   w_db_estado = 3'd7;
        endcase
    end

    assign bus.mem_endereco = addr_q;
    assign bus.leds         = (state_q == S_ACESO) ? leds_q : '0;
    assign bus.ocupado      = (state_q != S_OCIOSO);
    assign bus.pronto       = (state_q == S_FIM);
    assign bus.db_estado    = w_db_estado;

endmodule
`default_nettype wire

// File: tb/tb_exibe_sequencia.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exibe_sequencia
//  Purpose  : Scoreboard bench for exibe_sequencia (ADDR_W=2, T_ON=4,
//             T_OFF=2, memory 0x1,0x2,0x4,0x8). Stimulus pushes expected
//             LED-on, LED-off and pronto events; a monitor pops and compares
//             them as the DUT produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exibe_sequencia;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 4;
    localparam int T_ON   = 4;
    localparam int T_OFF  = 2;
    localparam int P      = 1 + T_ON + T_OFF;

    localparam int EV_ON     = 0;
    localparam int EV_OFF    = 1;
    localparam int EV_PRONTO = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
`ifdef EXIBE_SEQUENCIA_ABORTA_EN
    logic parar = 1'b0;
`endif

    exibe_sequencia_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic [DATA_W-1:0] mem [0:3];
    assign bus.mem_dado = mem[bus.mem_endereco];

    exibe_sequencia #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .T_ON   (T_ON),
        .T_OFF  (T_OFF)
    ) u_dut (
        .clock  (clock),
        .reset  (reset),
`ifdef EXIBE_SEQUENCIA_ABORTA_EN
        .parar  (parar),
`endif
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int cyc;
        int val;
        int addr;
        int db;
    } ev_t;

    ev_t exp_q[$];
    int  base     = 0;
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_ev(input int kind, input int c, input int val,
                                    input int addr, input int db);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        e.addr = addr;
        e.db   = db;
        exp_q.push_back(e);
    endfunction

    // Full presentation of entries 0..L, times taken from the period formula.
    function automatic void expect_run(input int L);
        for (int k = 0; k <= L; k++) begin
            push_ev(EV_ON,  2 + k * P,        1 << k, k, 2);
            push_ev(EV_OFF, 2 + k * P + T_ON, 0,      k, 3);
        end
        push_ev(EV_PRONTO, 1 + (L + 1) * P, 0, L, 4);
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] prev_leds = '0;

    task automatic handle(input int kind);
        ev_t e;
        int  rel;
        rel = cyc - base;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, rel);
        end else begin
            e = exp_q.pop_front();
            check("event_kind",   kind, e.kind);
            check("event_cycle",  rel,  e.cyc);
            check("leds",         32'(bus.leds),         e.val);
            check("mem_endereco", 32'(bus.mem_endereco), e.addr);
            check("db_estado",    32'(bus.db_estado),    e.db);
            check("ocupado",      32'(bus.ocupado),      32'(e.db != 0));
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            prev_leds = '0;
        end else begin
            if (bus.leds != '0 && prev_leds == '0) handle(EV_ON);
            if (bus.leds == '0 && prev_leds != '0) handle(EV_OFF);
            if (bus.pronto)                        handle(EV_PRONTO);
            prev_leds = bus.leds;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge, return at a falling edge)
    // ------------------------------------------------------------------
    task automatic start(input int L);
        bus.limite  = ADDR_W'(L);
        bus.iniciar = 1'b1;
        base        = cyc;
        @(negedge clock);
        bus.iniciar = 1'b0;
        check("carrega_db_estado", 32'(bus.db_estado), 1);
        check("carrega_ocupado",   32'(bus.ocupado),   1);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("events_drained", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clock);
        check("idle_ocupado",   32'(bus.ocupado),      0);
        check("idle_db_estado", 32'(bus.db_estado),    0);
        check("idle_endereco",  32'(bus.mem_endereco), 0);
    endtask

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin
        mem[0] = 4'h1;
        mem[1] = 4'h2;
        mem[2] = 4'h4;
        mem[3] = 4'h8;
        bus.iniciar = 1'b0;
        bus.limite  = '0;

        repeat (2) @(negedge clock);
        check("reset_leds",      32'(bus.leds),         0);
        check("reset_ocupado",   32'(bus.ocupado),      0);
        check("reset_pronto",    32'(bus.pronto),       0);
        check("reset_db_estado", 32'(bus.db_estado),    0);
        check("reset_endereco",  32'(bus.mem_endereco), 0);
        #2 reset = 1'b0;
        @(negedge clock);

        // 1: limite=2, three entries, pronto in cycle 22
        expect_run(2);
        start(2);
        wait_done(60);

        // 2: limite=0, single entry, pronto in cycle 8
        expect_run(0);
        start(0);
        wait_done(30);

        // 3: limite at top of address range, pronto in cycle 29
        expect_run(3);
        start(3);
        wait_done(60);

        // 4: stray iniciar at 3 and 22, limite changed at 4 -> same as test 1
        expect_run(2);
        start(2);
        repeat (2) @(negedge clock);
        bus.iniciar = 1'b1;
        @(negedge clock);
        bus.iniciar = 1'b0;
        bus.limite  = '0;
        repeat (18) @(negedge clock);
        bus.iniciar = 1'b1;
        @(negedge clock);
        bus.iniciar = 1'b0;
        wait_done(40);

        // 5: reset during entry 1 (cycle 10), then a fresh start
        push_ev(EV_ON,  2,        1, 0, 2);
        push_ev(EV_OFF, 2 + T_ON, 0, 0, 3);
        push_ev(EV_ON,  2 + P,    2, 1, 2);
        start(2);
        repeat (9) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midreset_leds",      32'(bus.leds),         0);
        check("midreset_ocupado",   32'(bus.ocupado),      0);
        check("midreset_db_estado", 32'(bus.db_estado),    0);
        check("midreset_pronto",    32'(bus.pronto),       0);
        check("midreset_endereco",  32'(bus.mem_endereco), 0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        check("midreset_events_seen", exp_q.size(), 0);
        exp_q.delete();
        repeat (30) @(negedge clock);
        expect_run(0);
        start(0);
        wait_done(30);

`ifdef EXIBE_SEQUENCIA_ABORTA_EN
        // 6: parar in cycle 3 -> idle in cycle 4, no pronto, then replay
        push_ev(EV_ON,  2, 1, 0, 2);
        push_ev(EV_OFF, 4, 0, 0, 0);
        start(2);
        repeat (2) @(negedge clock);
        parar = 1'b1;
        @(negedge clock);
        parar = 1'b0;
        check("abort_db_estado", 32'(bus.db_estado), 0);
        check("abort_ocupado",   32'(bus.ocupado),   0);
        repeat (30) @(negedge clock);
        check("abort_events_seen", exp_q.size(), 0);
        exp_q.delete();
        expect_run(0);
        start(0);
        wait_done(30);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/exibe_sequencia.md
Name: exibe_sequencia

Overview:
Sequence presenter for the memory game: plays the stored sequence to the player by reading positions 0..limite from the sequence memory and lighting the LEDs for each entry. Sits between the game's control unit and the sequence memory and LED outputs. The control unit pulses iniciar, and this block pulses pronto when presentation ends; the control unit then starts collecting jogadas. It is the outbound (game-to-player) side of the same player interface the control unit checks inbound.

Parameters:
ADDR_W, 4, width of memory address and limite.
DATA_W, 4, width of a memory word and of leds (one bit per button/LED).
T_ON, 1000, clock cycles each entry is lit (>=1).
T_OFF, 500, clock cycles of dark gap after each entry (>=1).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high; forces ocioso.
iniciar  input  1  start request, sampled only in ocioso.
limite  input  ADDR_W  index of last entry to show (inclusive); sampled at iniciar.
mem_dado  input  DATA_W  memory word at mem_endereco (asynchronous read, valid same cycle).
mem_endereco  output  ADDR_W  current read address.
leds  output  DATA_W  LED drive; zero when not in aceso.
ocupado  output  1  high in every state except ocioso.
pronto  output  1  one-cycle pulse in fim.
db_estado  output  3  current state code for debug.

Behaviour:
- Reset: state ocioso; mem_endereco=0, limite register=0, leds register=0, timer=0; leds=0, ocupado=0, pronto=0, db_estado=0.
- States and codes: ocioso 0, carrega 1, aceso 2, apagado 3, fim 4. Codes 5-7 are illegal; they return to ocioso next cycle and drive db_estado=7.
- ocioso:
  - iniciar=1 -> carrega; mem_endereco<=0; limite register<=limite.
  - iniciar=0 -> stay.
- carrega (1 cycle): leds register<=mem_dado; timer<=0; -> aceso.
- aceso:
  - leds = leds register; timer increments each cycle.
  - When timer==T_ON-1: timer<=0; -> apagado.
- apagado:
  - leds=0; timer increments each cycle.
  - When timer==T_OFF-1 and mem_endereco==limite register: -> fim.
  - When timer==T_OFF-1 otherwise: mem_endereco<=mem_endereco+1; -> carrega.
- fim (1 cycle): pronto=1; mem_endereco<=0; -> ocioso.
- Timing:
  - Period per entry P = 1+T_ON+T_OFF cycles.
  - If iniciar is sampled at edge 0, carrega is active in cycle 1.
  - Entry k is lit in cycles 2+k*P .. 1+k*P+T_ON.
  - pronto is high in cycle 1+(L+1)*P, where L is the latched limite.
- Timer width: $clog2 of the larger of T_ON and T_OFF, minimum 1 bit.
- Boundaries:
  - limite=0 shows exactly one entry.
  - limite=2^ADDR_W-1 shows all entries; mem_endereco never wraps, because the end test happens before the increment.
  - iniciar while ocupado is ignored; no restart and no queueing.
  - Changes to limite or mem_dado while ocupado do not affect the current entry (both are latched). mem_dado is resampled only in carrega.
  - iniciar in the same cycle as pronto (fim) is ignored; the next iniciar is taken in ocioso.
  - Reset mid-operation: leds drop to 0 immediately (async); pronto is not issued.
- Moore outputs, decoded from the state register and the leds register; no combinational path from inputs to outputs.

Optional Feature:
Macro EXIBE_SEQUENCIA_ABORTA_EN.
- Defined:
  - Adds input port parar (1 bit).
  - parar=1 in carrega, aceso or apagado -> next state ocioso; mem_endereco<=0; timer<=0; no pronto pulse. leds=0 from the next cycle.
  - parar has priority over every timer-end transition.
  - parar in ocioso or fim has no effect.
- Undefined: port absent; behaviour exactly as above.

Test Plan:
Bench parameters: T_ON=4, T_OFF=2, so P=7. Memory contents: 0x1, 0x2, 0x4, 0x8, ...
1. Reset, then iniciar pulse with limite=2 -> leds=0x1 in cycles 2-5, 0 in 6-7, 0x2 in 9-12, 0x4 in 16-19; mem_endereco sequence 0,1,2; pronto high only in cycle 22; ocupado high in cycles 1-22, then ocioso.
2. limite=0 -> one flash of 0x1 (cycles 2-5); pronto in cycle 8.
3. ADDR_W=2, limite=3 -> four flashes 0x1, 0x2, 0x4, 0x8; mem_endereco reaches 3 and never reads 0 again before fim; pronto in cycle 29.
4. Extra iniciar pulses at cycles 3 and 22, and limite changed to 0 at cycle 4, during run of test 1 -> output identical to test 1.
5. Reset asserted at cycle 10 of test 1 -> leds=0, ocupado=0, db_estado=0 at once; no pronto. A new iniciar restarts from address 0.
6. (EXIBE_SEQUENCIA_ABORTA_EN) parar=1 at cycle 3 of test 1 -> cycle 4 state ocioso, leds=0, pronto never asserted; a following iniciar replays from entry 0.
